// File: rtl/muln_seq.sv
// Sequential radix-2 shift-add multiplier, WIDTH cycles per product, start/done handshake.
// Define MULN_SIGNED_EN for two's-complement operands and product (sign-magnitude internally).
module muln_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   z
);

  localparam int CNT_W = $clog2(WIDTH+1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     mcand, mplr, hi;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   prod, z_fin;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 accept, last;

`ifdef MULN_SIGNED_EN
  logic sgn;
  always_comb begin
    // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude
    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;
    z_fin = sgn ? -prod : prod;
  end
`else
  always_comb begin
    a_mag = a;
    b_mag = b;
    z_fin = prod;
  end
`endif

  always_comb begin
    accept = start && (state != RUN);
    last   = (state == RUN) && (cnt == LAST);
    sum    = {1'b0, hi} + (mplr[0] ? {1'b0, mcand} : '0);
    // {carry, acc_hi, mplr} shifted right by one
    prod   = {sum, mplr[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      mplr  <= '0;
      hi    <= '0;
      cnt   <= '0;
      z     <= '0;
`ifdef MULN_SIGNED_EN
      sgn   <= 1'b0;
`endif
    end else if (accept) begin
      mcand <= a_mag;
      mplr  <= b_mag;
      hi    <= '0;
      cnt   <= '0;
`ifdef MULN_SIGNED_EN
      sgn   <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
    end else if (state == RUN) begin
      hi   <= sum[WIDTH:1];
      mplr <= prod[WIDTH-1:0];
      cnt  <= cnt + 1'b1;
      if (last) z <= z_fin;
    end
  end

endmodule

// File: tb/tb_muln_seq.sv
// Scoreboard bench for muln_seq: one WIDTH=4 and one WIDTH=8 instance against an arithmetic model.
module tb_muln_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        s0, s1, bz0, bz1, dn0, dn1;
  logic [3:0]  a0, b0;
  logic [7:0]  a1, b1, z0;
  logic [15:0] z1;

  always #5 clk = ~clk;

  muln_seq #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .start(s0), .a(a0), .b(b0),
                            .busy(bz0), .done(dn0), .z(z0));
  muln_seq #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1),
                            .busy(bz1), .done(dn1), .z(z1));

  typedef struct { int due; logic [15:0] v; } exp_t;
  exp_t        q0[$], q1[$];
  int          cyc = 0;
  int          vecs = 0, errs = 0;
  bit          chk_en = 0;
  int          last_acc[2];
  logic [15:0] zexp[2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] model(int w, logic [7:0] x, logic [7:0] y);
    longint mask, ux, uy, p;
    mask = (longint'(1) << w) - 1;
    ux = longint'(x) & mask;
    uy = longint'(y) & mask;
`ifdef MULN_SIGNED_EN
    if (x[w-1]) ux = ux - (longint'(1) << w);
    if (y[w-1]) uy = uy - (longint'(1) << w);
`endif
    p = ux * uy;
    return 16'(p & ((longint'(1) << (2*w)) - 1));
  endfunction

  task automatic chk(string nm, int d, logic [15:0] act, logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d cyc=%0d got %0h want %0h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic mon(int d, logic bz, logic dn, logic [15:0] zz);
    int   w;
    bit   bexp, have;
    exp_t e;
    w    = d ? 8 : 4;
    bexp = last_acc[d] >= 0 && cyc >= last_acc[d] && cyc < last_acc[d] + w;
    have = 0;
    if (d == 0) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1; end
    end else begin
      if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1; end
    end
    chk("busy", d, 16'(bz), 16'(bexp));
    chk("done", d, 16'(dn), 16'(have));
    if (have) zexp[d] = e.v;
    chk("z", d, zz, zexp[d]);
  endtask

  always @(negedge clk) if (chk_en) begin
    mon(0, bz0, dn0, 16'(z0));
    mon(1, bz1, dn1, z1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(int t);
    while (cyc < t) tick();
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    q0.delete();
    q1.delete();
    last_acc = '{-1, -1};
    zexp     = '{16'h0, 16'h0};
    chk_en   = 1;
    tick();
    rst = 1'b0;
  endtask

  // Drive start for one edge; the model decides whether that edge accepts it
  task automatic issue(int d, logic [7:0] x, logic [7:0] y);
    int w;
    w = d ? 8 : 4;
    if (d == 0) begin s0 = 1'b1; a0 = x[3:0]; b0 = y[3:0]; end
    else        begin s1 = 1'b1; a1 = x;      b1 = y;      end
    tick();
    if (last_acc[d] < 0 || cyc >= last_acc[d] + w + 1) begin
      last_acc[d] = cyc;
      if (d == 0) q0.push_back('{cyc + w, model(w, x, y)});
      else        q1.push_back('{cyc + w, model(w, x, y)});
    end
    if (d == 0) begin s0 = 1'b0; a0 = 4'($urandom); b0 = 4'($urandom); end
    else        begin s1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom); end
  endtask

  task automatic settle(int d);
    wait_to(last_acc[d] + (d ? 8 : 4) + 2);
  endtask

  initial begin
    rst = 1'b1; s0 = 1'b0; s1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    tick();
    do_reset();
    tick();

    issue(0, 8'd2, 8'd2);   settle(0); tick();
    issue(0, 8'd15, 8'd15);
    wait_to(last_acc[0] + 4);
    issue(0, 8'd3, 8'd6);   settle(0);
    issue(0, 8'd5, 8'd2);   tick();
    issue(0, 8'd7, 8'd1);   settle(0);
    issue(0, 8'd3, 8'd6);   tick();
    do_reset();
    repeat (8) tick();
    issue(1, 8'd255, 8'd255); settle(1);
    issue(1, 8'd0, 8'd200);   settle(1);
`ifdef MULN_SIGNED_EN
    issue(0, 8'h0D, 8'd5);  settle(0);
    issue(0, 8'h08, 8'h08); settle(0);
    issue(1, 8'h80, 8'h80); settle(1);
`endif

    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 6)) tick();
      if ($urandom_range(0, 49) == 0) do_reset();
      issue(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end

    repeat (12) tick();
    chk("drain", 0, 16'(q0.size() + q1.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
